keypad_matrix_scanner: RTL and testbench
========================================

Name: keypad_matrix_scanner

Overview:
- Parametrised successor to the fixed 4x3 keypad scanner.
- Drives a ROWS x COLS matrix one row at a time and synchronises the column inputs.
- Debounces both press and release, and emits a latched key index with a one-cycle valid strobe.
- Optional auto-repeat. Sits between the matrix pins and the display/decoder logic, running from the system clock rather than a derived scan clock.

Parameters:
- ROWS, 4, number of row drivers (2..8).
- COLS, 3, number of column receivers (2..8).
- SCAN_DIV, 1000, system clocks per scan tick (>=4; covers synchroniser latency plus settling).
- DEBOUNCE_TICKS, 8, consecutive stable ticks required to accept a press or a release (>=1).
- REPEAT_TICKS, 0, ticks between auto-repeat strobes while held; 0 disables repeat.

Ports:
- clock, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high.
- rowDrivers, output, ROWS: one-hot, active-high row drive (pull-down matrix).
- columnReceivers, input, COLS: raw asynchronous column sense, active-high.
- keyCode, output, KEY_W = clog2(ROWS*COLS): row*COLS+col of the last accepted key.
- keyValid, output, 1: one-clock pulse when keyCode is (re)issued.
- keyHeld, output, 1: high from press acceptance until release acceptance.

Behaviour:
Reset values:
- rowDrivers = 1 (row 0), keyCode = 0, keyValid = 0, keyHeld = 0.
- Prescaler = 0, debounce/repeat counters = 0, state = SCAN.
- Synchroniser flops = 0.
- Reset asserted mid-operation aborts any state on the next edge. No keyValid is produced in the cycle that reset is high.

Timing:
- columnReceivers pass through a 2-flop synchroniser; colSync is used everywhere below.
- Prescaler counts 0..SCAN_DIV-1. scanTick is high for one clock when the count equals SCAN_DIV-1, then the count wraps.
- All FSM actions happen only on scanTick cycles. keyValid is asserted for exactly one clock on a scanTick edge and deasserted otherwise.

State SCAN:
- On a tick, sample colSync for the current row.
- If nonzero: lowest-index set column wins. Latch candidate = row*COLS+col, set debounceCount = 1, hold the row, go to PRESS_DB.
- If zero: advance the row, wrapping ROWS-1 -> 0.

State PRESS_DB (row held):
- Candidate column still set on a tick: increment the count.
- Count reaches DEBOUNCE_TICKS: keyCode <= candidate, keyValid pulse, keyHeld <= 1, repeatCount <= 0, go to HELD.
- Candidate column clear on a tick: go to SCAN and advance the row.
- A different column in the same row appearing does not restart debounce; only the candidate bit matters.

State HELD:
- Candidate bit clear on a tick: debounceCount = 1, go to REL_DB.
- Otherwise, if REPEAT_TICKS != 0, increment repeatCount. At REPEAT_TICKS: keyValid pulse with the same keyCode, repeatCount <= 0.

State REL_DB:
- Bit set again on a tick: return to HELD with repeatCount preserved.
- Bit clear for DEBOUNCE_TICKS consecutive ticks: keyHeld <= 0, go to SCAN and advance the row.
- keyCode retains its value after release.

Multi-key and width rules:
- Multiple simultaneous keys: only the first found in scan order is reported. Others are ignored until release; a still-pressed second key is found on subsequent scans.
- Press latency, from a stable column to keyValid: at most ROWS + DEBOUNCE_TICKS - 1 ticks, plus 2 clocks for the synchroniser.
- Counters are sized to their parameter with no overflow: debounce clog2(DEBOUNCE_TICKS+1), repeat clog2(REPEAT_TICKS+1), prescaler clog2(SCAN_DIV).
- keyCode arithmetic is done at KEY_W bits. ROWS*COLS <= 64.

Decomposition:
- Shared package keypad_pkg holds:
  - The state encoding (SCAN, PRESS_DB, HELD, REL_DB).
  - The clog2 width function.
  - KEY_W derivation.
- One sub-module, scan_prescaler: parametrised by SCAN_DIV, ports clock/reset, outputs scanTick.
- Everything else (synchroniser, row ring, FSM, counters) lives in keypad_matrix_scanner.

Test Plan (ROWS=4, COLS=3, SCAN_DIV=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=0 unless stated):
1. Reset, no keys -> rowDrivers cycles 0001, 0010, 0100, 1000, 0001 with the row advancing every 4 clocks; keyValid and keyHeld stay 0.
2. Press row 2, col 1 cleanly -> keyValid pulses once with keyCode = 7 and keyHeld = 1; rowDrivers holds 0100. Release -> keyHeld drops after 3 ticks and scanning resumes at row 3.
3. Bounce on row 0, col 0 (present 1 tick, absent 1 tick, repeated) -> no keyValid. Then stable for 3 ticks -> keyValid with keyCode = 0.
4. Keys row 1, col 2 and row 1, col 0 pressed together -> keyCode = 3 (lowest column wins); exactly one keyValid.
5. REPEAT_TICKS = 5, hold row 3, col 2 for 20 ticks after acceptance -> keyValid pulses at acceptance and then every 5 ticks (4 pulses), all with keyCode = 11. Release glitch of 1 tick -> no keyHeld drop.
6. Assert reset during PRESS_DB -> next clock: rowDrivers = 0001, keyHeld = 0, and no keyValid for that press until it is debounced again from scratch.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad matrix scanner: FSM state encoding and width helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

    function automatic int key_width(input int rows, input int cols);
        return clog2(rows * cols);
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_prescaler.sv
// Scan-rate prescaler: one-clock scanTick every SCAN_DIV system clocks.
module scan_prescaler
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic clock,
    input  logic reset,
    output logic scanTick
);

    localparam int CNT_W = clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q + 1'b1;
        if (count_q == CNT_LAST) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign scanTick = (count_q == CNT_LAST);

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-scanned keypad matrix reader with press/release debounce and optional auto-repeat.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 3,
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 8,
    parameter int REPEAT_TICKS   = 0,
    localparam int KEY_W         = key_width(ROWS, COLS)
) (
    input  logic             clock,
    input  logic             reset,
    output logic [ROWS-1:0]  rowDrivers,
    input  logic [COLS-1:0]  columnReceivers,
    output logic [KEY_W-1:0] keyCode,
    output logic             keyValid,
    output logic             keyHeld
);

    localparam int ROW_W = clog2(ROWS);
    localparam int COL_W = clog2(COLS);
    localparam int DEB_W = clog2(DEBOUNCE_TICKS + 1);
    localparam int REP_W = clog2(REPEAT_TICKS + 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

    logic             scanTick;
    logic [COLS-1:0]  sync1_q;
    logic [COLS-1:0]  colSync_q;
    state_t           state_q,    state_d;
    logic [ROW_W-1:0] row_q,      row_d;
    logic [COL_W-1:0] candCol_q,  candCol_d;
    logic [KEY_W-1:0] candKey_q,  candKey_d;
    logic [DEB_W-1:0] debounce_q, debounce_d;
    logic [REP_W-1:0] repeat_q,   repeat_d;
    logic [KEY_W-1:0] keyCode_q,  keyCode_d;
    logic             keyValid_q, keyValid_d;
    logic             keyHeld_q,  keyHeld_d;

    logic             hit;
    logic             candBit;
    logic [COL_W-1:0] hitCol;
    logic [KEY_W-1:0] hitKey;
    logic [ROW_W-1:0] rowNext;

    scan_prescaler #(
        .SCAN_DIV(SCAN_DIV)
    ) u_prescaler (
        .clock   (clock),
        .reset   (reset),
        .scanTick(scanTick)
    );

    // Descending walk so the lowest set column is the one left standing.
    always_comb begin
        hitCol = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (colSync_q[c]) begin
                hitCol = COL_W'(c);
            end
        end
    end

    assign hit     = |colSync_q;
    assign candBit = colSync_q[candCol_q];
    assign hitKey  = KEY_W'(row_q) * KEY_W'(COLS) + KEY_W'(hitCol);
    assign rowNext = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;

    always_comb begin
        rowDrivers        = '0;
        rowDrivers[row_q] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        candCol_d  = candCol_q;
        candKey_d  = candKey_q;
        debounce_d = debounce_q;
        repeat_d   = repeat_q;
        keyCode_d  = keyCode_q;
        keyValid_d = 1'b0;
        keyHeld_d  = keyHeld_q;
        if (scanTick) begin
            case (state_q)
                SCAN: begin
                    if (hit) begin
                        candCol_d  = hitCol;
                        candKey_d  = hitKey;
                        debounce_d = DEB_W'(1);
                        state_d    = PRESS_DB;
                    end else begin
                        row_d = rowNext;
                    end
                end
                PRESS_DB: begin
                    if (!candBit) begin
                        state_d = SCAN;
                        row_d   = rowNext;
                    end else if (debounce_q >= DEB_LAST) begin
                        keyCode_d  = candKey_q;
                        keyValid_d = 1'b1;
                        keyHeld_d  = 1'b1;
                        repeat_d   = '0;
                        state_d    = HELD;
                    end else begin
                        debounce_d = debounce_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!candBit) begin
                        debounce_d = DEB_W'(1);
                        state_d    = REL_DB;
                    end else if (REPEAT_TICKS != 0) begin
                        if (repeat_q >= REP_LAST) begin
                            keyValid_d = 1'b1;
                            repeat_d   = '0;
                        end else begin
                            repeat_d = repeat_q + 1'b1;
                        end
                    end
                end
                REL_DB: begin
                    // A bounce back to pressed resumes the hold without losing repeat phase.
                    if (candBit) begin
                        state_d = HELD;
                    end else if (debounce_q >= DEB_LAST) begin
                        keyHeld_d = 1'b0;
                        state_d   = SCAN;
                        row_d     = rowNext;
                    end else begin
                        debounce_d = debounce_q + 1'b1;
                    end
                end
                default: begin
                    state_d = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= '0;
            colSync_q  <= '0;
            state_q    <= SCAN;
            row_q      <= '0;
            candCol_q  <= '0;
            candKey_q  <= '0;
            debounce_q <= '0;
            repeat_q   <= '0;
            keyCode_q  <= '0;
            keyValid_q <= 1'b0;
            keyHeld_q  <= 1'b0;
        end else begin
            sync1_q    <= columnReceivers;
            colSync_q  <= sync1_q;
            state_q    <= state_d;
            row_q      <= row_d;
            candCol_q  <= candCol_d;
            candKey_q  <= candKey_d;
            debounce_q <= debounce_d;
            repeat_q   <= repeat_d;
            keyCode_q  <= keyCode_d;
            keyValid_q <= keyValid_d;
            keyHeld_q  <= keyHeld_d;
        end
    end

    assign keyCode  = keyCode_q;
    assign keyValid = keyValid_q;
    assign keyHeld  = keyHeld_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner: a plain instance plus an auto-repeat instance.
module tb_keypad_matrix_scanner;

    logic        clock;
    logic        reset;
    logic [3:0]  rows_a, rows_b;
    logic [2:0]  cols_a, cols_b;
    logic [3:0]  code_a, code_b;
    logic        valid_a, valid_b;
    logic        held_a, held_b;
    logic [11:0] keys_a, keys_b;

    int n_checks;
    int n_pass;

    keypad_matrix_scanner #(
        .ROWS(4), .COLS(3), .SCAN_DIV(4), .DEBOUNCE_TICKS(3), .REPEAT_TICKS(0)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .rowDrivers     (rows_a),
        .columnReceivers(cols_a),
        .keyCode        (code_a),
        .keyValid       (valid_a),
        .keyHeld        (held_a)
    );

    keypad_matrix_scanner #(
        .ROWS(4), .COLS(3), .SCAN_DIV(4), .DEBOUNCE_TICKS(3), .REPEAT_TICKS(5)
    ) u_rep (
        .clock          (clock),
        .reset          (reset),
        .rowDrivers     (rows_b),
        .columnReceivers(cols_b),
        .keyCode        (code_b),
        .keyValid       (valid_b),
        .keyHeld        (held_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pull-down matrix: a pressed key connects its driven row to its column.
    always_comb begin
        cols_a = '0;
        cols_b = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (rows_a[r] && keys_a[r*3+c]) cols_a[c] = 1'b1;
                if (rows_b[r] && keys_b[r*3+c]) cols_b[c] = 1'b1;
            end
        end
    end

    task automatic wait_row_a(input logic [3:0] target, input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 64; i++) begin
            if (rows_a == target) begin
                found = 1;
                break;
            end
            @(negedge clock);
        end
        n_checks++;
        if (!found) $display("FAIL %s: rowDrivers never reached %b (now %b)", name, target, rows_a);
        else n_pass++;
    endtask

    task automatic test_reset();
        keys_a = '0;
        keys_b = '0;
        reset  = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if (rows_a !== 4'b0001) $display("FAIL reset_rows: got %b want 0001", rows_a);
        else n_pass++;
        n_checks++;
        if (code_a !== 4'd0) $display("FAIL reset_code: got %0d want 0", code_a);
        else n_pass++;
        n_checks++;
        if (valid_a !== 1'b0 || held_a !== 1'b0)
            $display("FAIL reset_flags: valid=%b held=%b want 0 0", valid_a, held_a);
        else n_pass++;
        n_checks++;
        if (rows_b !== 4'b0001 || held_b !== 1'b0 || valid_b !== 1'b0)
            $display("FAIL reset_rep: rows=%b held=%b valid=%b want 0001 0 0", rows_b, held_b, valid_b);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_scan();
        logic [3:0] exp_rows;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            exp_rows = 4'b0001 << (((k + 1) / 4) % 4);
            n_checks++;
            if (rows_a !== exp_rows || valid_a !== 1'b0 || held_a !== 1'b0)
                $display("FAIL scan_k%0d: rows=%b valid=%b held=%b want %b 0 0",
                         k, rows_a, valid_a, held_a, exp_rows);
            else n_pass++;
        end
    endtask

    task automatic test_press_release();
        bit early;
        wait_row_a(4'b0010, "press_sync1");
        wait_row_a(4'b0100, "press_sync2");
        keys_a[7] = 1'b1;
        early = 0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clock);
            if (valid_a !== 1'b0) early = 1;
        end
        n_checks++;
        if (early) $display("FAIL press_early: keyValid before debounce complete, got 1 want 0");
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (valid_a !== 1'b1 || code_a !== 4'd7 || held_a !== 1'b1 || rows_a !== 4'b0100)
            $display("FAIL press_accept: valid=%b code=%0d held=%b rows=%b want 1 7 1 0100",
                     valid_a, code_a, held_a, rows_a);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (valid_a !== 1'b0 || rows_a !== 4'b0100)
            $display("FAIL press_pulse: valid=%b rows=%b want 0 0100", valid_a, rows_a);
        else n_pass++;
        keys_a[7] = 1'b0;
        early = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (held_a !== 1'b1) early = 1;
        end
        n_checks++;
        if (early) $display("FAIL release_early: keyHeld dropped before 3 ticks, got 0 want 1");
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (held_a !== 1'b0 || rows_a !== 4'b1000 || code_a !== 4'd7 || valid_a !== 1'b0)
            $display("FAIL release_done: held=%b rows=%b code=%0d valid=%b want 0 1000 7 0",
                     held_a, rows_a, code_a, valid_a);
        else n_pass++;
    endtask

    task automatic test_bounce();
        bit bad;
        bit seen;
        int extra;
        wait_row_a(4'b0001, "bounce_sync1");
        wait_row_a(4'b0010, "bounce_sync2");
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            keys_a[0] = ~keys_a[0];
            repeat (4) begin
                @(negedge clock);
                if (valid_a !== 1'b0 || held_a !== 1'b0) bad = 1;
            end
        end
        n_checks++;
        if (bad) $display("FAIL bounce_reject: keyValid/keyHeld seen during bounce, got 1 want 0");
        else n_pass++;
        keys_a[0] = 1'b1;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (valid_a === 1'b1) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen || code_a !== 4'd0 || held_a !== 1'b1)
            $display("FAIL bounce_accept: seen=%b code=%0d held=%b want 1 0 1", seen, code_a, held_a);
        else n_pass++;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (valid_a === 1'b1) extra++;
        end
        n_checks++;
        if (extra != 0) $display("FAIL bounce_single: extra pulses got %0d want 0", extra);
        else n_pass++;
        keys_a[0] = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (held_a === 1'b0) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL bounce_release: keyHeld got 1 want 0");
        else n_pass++;
    endtask

    task automatic test_two_keys();
        int pulses;
        bit seen;
        keys_a[5] = 1'b1;
        keys_a[3] = 1'b1;
        pulses = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clock);
            if (valid_a === 1'b1) begin
                pulses++;
                n_checks++;
                if (code_a !== 4'd3) $display("FAIL two_keys_code: got %0d want 3", code_a);
                else n_pass++;
            end
        end
        n_checks++;
        if (pulses != 1) $display("FAIL two_keys_count: pulses got %0d want 1", pulses);
        else n_pass++;
        keys_a[5] = 1'b0;
        keys_a[3] = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (held_a === 1'b0) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL two_keys_release: keyHeld got 1 want 0");
        else n_pass++;
    endtask

    task automatic test_repeat();
        bit seen;
        bit drop;
        int pulses;
        int first;
        int badcode;
        keys_b[11] = 1'b1;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (valid_b === 1'b1) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen || code_b !== 4'd11 || held_b !== 1'b1)
            $display("FAIL repeat_accept: seen=%b code=%0d held=%b want 1 11 1", seen, code_b, held_b);
        else n_pass++;
        pulses = 0;
        first = -1;
        badcode = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clock);
            if (valid_b === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
                if (code_b !== 4'd11) badcode++;
            end
        end
        n_checks++;
        if (pulses != 4) $display("FAIL repeat_count: pulses got %0d want 4", pulses);
        else n_pass++;
        n_checks++;
        if (first != 20) $display("FAIL repeat_period: first repeat at clock %0d want 20", first);
        else n_pass++;
        n_checks++;
        if (badcode != 0) $display("FAIL repeat_code: %0d pulses with code other than 11, want 0", badcode);
        else n_pass++;
        keys_b[11] = 1'b0;
        repeat (4) @(negedge clock);
        keys_b[11] = 1'b1;
        drop = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (held_b !== 1'b1) drop = 1;
        end
        n_checks++;
        if (drop) $display("FAIL repeat_glitch: keyHeld dropped on 1-tick glitch, got 0 want 1");
        else n_pass++;
        keys_b[11] = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (held_b === 1'b0) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL repeat_release: keyHeld got 1 want 0");
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit early;
        bit seen;
        wait_row_a(4'b0001, "rst_sync1");
        wait_row_a(4'b0010, "rst_sync2");
        keys_a[4] = 1'b1;
        repeat (5) @(negedge clock);
        n_checks++;
        if (rows_a !== 4'b0010 || held_a !== 1'b0 || valid_a !== 1'b0)
            $display("FAIL rst_predb: rows=%b held=%b valid=%b want 0010 0 0", rows_a, held_a, valid_a);
        else n_pass++;
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (rows_a !== 4'b0001 || held_a !== 1'b0 || valid_a !== 1'b0)
            $display("FAIL rst_abort: rows=%b held=%b valid=%b want 0001 0 0", rows_a, held_a, valid_a);
        else n_pass++;
        reset = 1'b0;
        early = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            if (valid_a !== 1'b0) early = 1;
        end
        n_checks++;
        if (early) $display("FAIL rst_early: keyValid before fresh debounce, got 1 want 0");
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (valid_a !== 1'b1 || code_a !== 4'd4)
            $display("FAIL rst_redebounce: valid=%b code=%0d want 1 4", valid_a, code_a);
        else n_pass++;
        keys_a[4] = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (held_a === 1'b0) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL rst_release: keyHeld got 1 want 0");
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        keys_a   = '0;
        keys_b   = '0;
        test_reset();
        test_scan();
        test_press_release();
        test_bounce();
        test_two_keys();
        test_repeat();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
